// File: rtl/microsequencer.sv
// Microstate sequencer: selects the next microstore address from decode, increment,
// jump, conditional branch or memory-wait hold, with a MOC timeout and illegal-code flag.
module microsequencer #(
  parameter int unsigned        STATE_W     = 5,
  parameter logic [STATE_W-1:0] FETCH_STATE = '0,
  parameter logic [STATE_W-1:0] ERR_STATE   = '1,
  parameter int unsigned        MOC_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [STATE_W-1:0] enc_state,
  input  logic [STATE_W-1:0] cr_addr,
  input  logic [2:0]         ns_sel,
  input  logic               cond,
  input  logic               cond_inv,
  input  logic               moc,
  output logic [STATE_W-1:0] state,
  output logic               decode_strobe,
  output logic               waiting,
  output logic               illegal,
  output logic               err
);

  typedef enum logic [2:0] {
    NS_DECODE = 3'b000,
    NS_INC    = 3'b001,
    NS_JUMP   = 3'b010,
    NS_COND   = 3'b011,
    NS_WAIT   = 3'b100,
    NS_FETCH  = 3'b101,
    NS_RSV0   = 3'b110,
    NS_RSV1   = 3'b111
  } ns_sel_e;

  localparam logic [7:0] LAST_CNT = 8'(MOC_TIMEOUT - 1);

  logic [STATE_W-1:0] r_state;
  logic [7:0]         r_wait_cnt;
  logic               r_decode_strobe;
  logic               r_illegal;
  logic               r_err;

  ns_sel_e            w_sel;
  logic               w_cond;
  logic [STATE_W-1:0] w_state_inc;
  logic [STATE_W-1:0] w_next_state;
  logic [7:0]         w_next_cnt;
  logic               w_next_strobe;
  logic               w_next_illegal;
  logic               w_set_err;

  assign w_sel       = ns_sel_e'(ns_sel);
  assign w_cond      = cond ^ cond_inv;
  assign w_state_inc = r_state + STATE_W'(1);

  always_comb begin
    w_next_state   = r_state;
    w_next_cnt     = '0;
    w_next_strobe  = 1'b0;
    w_next_illegal = 1'b0;
    w_set_err      = 1'b0;
    unique case (w_sel)
      NS_DECODE: begin
        w_next_state  = enc_state;
        w_next_strobe = 1'b1;
      end
      NS_INC:   w_next_state = w_state_inc;
      NS_JUMP:  w_next_state = cr_addr;
      NS_COND:  w_next_state = w_cond ? cr_addr : w_state_inc;
      NS_WAIT: begin
        // moc wins over a timeout landing on the same edge
        if (moc) begin
          w_next_state = w_state_inc;
        end else if (r_wait_cnt == LAST_CNT) begin
          w_next_state = ERR_STATE;
          w_set_err    = 1'b1;
        end else begin
          w_next_cnt = r_wait_cnt + 8'd1;
        end
      end
      NS_FETCH: w_next_state = FETCH_STATE;
      NS_RSV0, NS_RSV1: begin
        w_next_state   = FETCH_STATE;
        w_next_illegal = 1'b1;
      end
      default:  w_next_state = FETCH_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= FETCH_STATE;
      r_wait_cnt      <= '0;
      r_decode_strobe <= 1'b0;
      r_illegal       <= 1'b0;
      r_err           <= 1'b0;
    end else begin
      r_state         <= w_next_state;
      r_wait_cnt      <= w_next_cnt;
      r_decode_strobe <= w_next_strobe;
      r_illegal       <= w_next_illegal;
      r_err           <= r_err | w_set_err;
    end
  end

  assign state         = r_state;
  assign decode_strobe = r_decode_strobe;
  assign illegal       = r_illegal;
  assign err           = r_err;
  assign waiting       = (w_sel == NS_WAIT) && !moc;

endmodule

// File: tb/tb_microsequencer.sv
// Directed bench for microsequencer: vector table for single-cycle selects, then
// hand sequences for the MOC handshake, timeout, sticky err and async reset.
module tb_microsequencer;

  logic       clk;
  logic       reset_n;
  logic [4:0] enc_state;
  logic [4:0] cr_addr;
  logic [2:0] ns_sel;
  logic       cond;
  logic       cond_inv;
  logic       moc;
  logic [4:0] state;
  logic       decode_strobe;
  logic       waiting;
  logic       illegal;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  microsequencer #(
    .STATE_W    (5),
    .FETCH_STATE(5'b00000),
    .ERR_STATE  (5'b11111),
    .MOC_TIMEOUT(16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enc_state    (enc_state),
    .cr_addr      (cr_addr),
    .ns_sel       (ns_sel),
    .cond         (cond),
    .cond_inv     (cond_inv),
    .moc          (moc),
    .state        (state),
    .decode_strobe(decode_strobe),
    .waiting      (waiting),
    .illegal      (illegal),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] ns;
    logic [4:0] enc;
    logic [4:0] cr;
    logic       c;
    logic       ci;
    logic       m;
    logic [4:0] st;
    logic       stb;
    logic       ill;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [2:0] ns, input logic [4:0] enc, input logic [4:0] cr,
                       input logic c, input logic ci, input logic m);
    ns_sel = ns; enc_state = enc; cr_addr = cr; cond = c; cond_inv = ci; moc = m;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // enc_state carries junk 10101 whenever ns_sel is not decode
    vecs[0]  = '{3'b000, 5'b11001, 5'b00000, 1'b0, 1'b0, 1'b0, 5'b11001, 1'b1, 1'b0};
    vecs[1]  = '{3'b010, 5'b10101, 5'b11111, 1'b0, 1'b0, 1'b0, 5'b11111, 1'b0, 1'b0};
    vecs[2]  = '{3'b001, 5'b10101, 5'b00000, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0};
    vecs[3]  = '{3'b010, 5'b10101, 5'b11001, 1'b0, 1'b0, 1'b0, 5'b11001, 1'b0, 1'b0};
    vecs[4]  = '{3'b011, 5'b10101, 5'b11100, 1'b1, 1'b0, 1'b0, 5'b11100, 1'b0, 1'b0};
    vecs[5]  = '{3'b010, 5'b10101, 5'b11001, 1'b0, 1'b0, 1'b0, 5'b11001, 1'b0, 1'b0};
    vecs[6]  = '{3'b011, 5'b10101, 5'b11100, 1'b1, 1'b1, 1'b0, 5'b11010, 1'b0, 1'b0};
    vecs[7]  = '{3'b011, 5'b10101, 5'b00011, 1'b0, 1'b1, 1'b0, 5'b00011, 1'b0, 1'b0};
    vecs[8]  = '{3'b011, 5'b10101, 5'b11110, 1'b0, 1'b0, 1'b0, 5'b00100, 1'b0, 1'b0};
    vecs[9]  = '{3'b101, 5'b10101, 5'b11110, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0};
    vecs[10] = '{3'b110, 5'b10101, 5'b11110, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b1};
    vecs[11] = '{3'b001, 5'b10101, 5'b11110, 1'b0, 1'b0, 1'b0, 5'b00001, 1'b0, 1'b0};
    vecs[12] = '{3'b111, 5'b10101, 5'b11110, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b1};
    vecs[13] = '{3'b000, 5'b00111, 5'b11110, 1'b0, 1'b0, 1'b0, 5'b00111, 1'b1, 1'b0};

    reset_n = 1'b0;
    drive(3'b000, 5'b00000, 5'b00000, 1'b0, 1'b0, 1'b0);
    #12;
    chk("reset_state", int'(state), 0);
    chk("reset_strobe", int'(decode_strobe), 0);
    chk("reset_illegal", int'(illegal), 0);
    chk("reset_err", int'(err), 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].ns, vecs[i].enc, vecs[i].cr, vecs[i].c, vecs[i].ci, vecs[i].m);
      tick();
      chk($sformatf("vec%0d_state", i), int'(state), int'(vecs[i].st));
      chk($sformatf("vec%0d_strobe", i), int'(decode_strobe), int'(vecs[i].stb));
      chk($sformatf("vec%0d_illegal", i), int'(illegal), int'(vecs[i].ill));
      chk($sformatf("vec%0d_err", i), int'(err), 0);
    end

    // MOC handshake: three low cycles then moc high
    drive(3'b010, 5'b10101, 5'b10000, 1'b0, 1'b0, 1'b0);
    tick();
    chk("moc_setup", int'(state), 5'b10000);
    drive(3'b100, 5'b10101, 5'b00000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("moc_waiting%0d", i), int'(waiting), 1);
      tick();
      chk($sformatf("moc_hold%0d", i), int'(state), 5'b10000);
    end
    moc = 1'b1;
    #1;
    chk("moc_waiting_hi", int'(waiting), 0);
    tick();
    chk("moc_done_state", int'(state), 5'b10001);
    chk("moc_done_err", int'(err), 0);

    // Timeout on the 16th low edge
    drive(3'b010, 5'b10101, 5'b00101, 1'b0, 1'b0, 1'b0);
    tick();
    drive(3'b100, 5'b10101, 5'b00000, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk($sformatf("to_hold%0d", i), int'(state), 5'b00101);
      chk($sformatf("to_noerr%0d", i), int'(err), 0);
    end
    tick();
    chk("to_state", int'(state), 5'b11111);
    chk("to_err", int'(err), 1);

    // err stays set while sequencing continues
    drive(3'b010, 5'b10101, 5'b00010, 1'b0, 1'b0, 1'b0);
    tick();
    chk("sticky_state", int'(state), 5'b00010);
    chk("sticky_err", int'(err), 1);

    // Asynchronous reset mid-wait, checked before any clock edge
    drive(3'b100, 5'b10101, 5'b00000, 1'b0, 1'b0, 1'b0);
    tick(); tick(); tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset_state", int'(state), 0);
    chk("areset_err", int'(err), 0);
    ns_sel = 3'b101;
    @(negedge clk);
    reset_n = 1'b1;

    // moc rises exactly on the 16th edge
    drive(3'b010, 5'b10101, 5'b01000, 1'b0, 1'b0, 1'b0);
    tick();
    drive(3'b100, 5'b10101, 5'b00000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) tick();
    chk("race_hold", int'(state), 5'b01000);
    moc = 1'b1;
    tick();
    chk("race_state", int'(state), 5'b01001);
    chk("race_err", int'(err), 0);

    // wait_cnt cleared by moc: another 15 low cycles must not time out
    moc = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("clr_moc_state", int'(state), 5'b01001);
    chk("clr_moc_err", int'(err), 0);

    // wait_cnt cleared by a non-wait select, then full timeout
    ns_sel = 3'b001;
    tick();
    chk("clr_sel_state", int'(state), 5'b01010);
    ns_sel = 3'b100;
    for (int i = 0; i < 15; i++) tick();
    chk("clr_sel_hold", int'(state), 5'b01010);
    chk("clr_sel_noerr", int'(err), 0);
    tick();
    chk("clr_sel_to_state", int'(state), 5'b11111);
    chk("clr_sel_to_err", int'(err), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
